// File: rtl/pwm_carrier_pkg.sv
// pwm_carrier_pkg: state, mode and reload-point encodings shared by the PWM carrier generator.
package pwm_carrier_pkg;
    typedef enum logic [1:0] {STOPPED, COUNT_UP, COUNT_DOWN} state_t;
    localparam logic SAWTOOTH = 1'b0;
    localparam logic TRIANGLE = 1'b1;
    localparam logic [1:0] RELOAD_ZERO   = 2'd0;
    localparam logic [1:0] RELOAD_PERIOD = 2'd1;
    localparam logic [1:0] RELOAD_BOTH   = 2'd2;
    localparam logic [1:0] RELOAD_NEVER  = 2'd3;
    function automatic logic reload_hit(input logic [1:0] sel, input logic at_zero, input logic at_period);
        return sel == RELOAD_ZERO ? at_zero :
               sel == RELOAD_PERIOD ? at_period :
               sel == RELOAD_BOTH ? (at_zero | at_period) : 1'b0;
    endfunction
endpackage

// File: rtl/pwm_carrier_counter_if.sv
// pwm_carrier_counter_if: control inputs and carrier outputs of the PWM carrier generator.
interface pwm_carrier_counter_if #(
    parameter int COUNTER_WIDTH   = 16,
    parameter int PRESCALER_WIDTH = 8
);
    logic                       enable;
    logic                       mode;
    logic [COUNTER_WIDTH-1:0]   period;
    logic [COUNTER_WIDTH-1:0]   start_value;
    logic [PRESCALER_WIDTH-1:0] prescale;
    logic [1:0]                 reload_sel;
    logic                       sync_in;
    logic [COUNTER_WIDTH-1:0]   counter_value;
    logic                       counter_stopped;
    logic                       reload_compare;
    logic                       direction;
    modport master (
        output enable, mode, period, start_value, prescale, reload_sel, sync_in,
        input  counter_value, counter_stopped, reload_compare, direction
    );
    modport slave (
        input  enable, mode, period, start_value, prescale, reload_sel, sync_in,
        output counter_value, counter_stopped, reload_compare, direction
    );
endinterface

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides the clock into a one-cycle tick every divisor+1 clocks.
module pwm_prescaler #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] divisor,
    output logic             tick
);
    logic [WIDTH-1:0] count;
    // >= keeps the divider from running the full range if the divisor shrinks mid-count
    assign tick = !clear && count >= divisor;
    always_ff @(posedge clock)
        count <= (reset || clear || tick) ? '0 : count + 1'b1;
endmodule

// File: rtl/pwm_carrier_counter.sv
// pwm_carrier_counter: sawtooth/triangle carrier with prescaler, shadowed period and phase sync.
module pwm_carrier_counter
    import pwm_carrier_pkg::*;
#(
    parameter int COUNTER_WIDTH   = 16,
    parameter int PRESCALER_WIDTH = 8
) (
    input logic                  clock,
    input logic                  reset,
    pwm_carrier_counter_if.slave bus
);
    typedef logic [COUNTER_WIDTH-1:0] cnt_t;
    state_t state, state_n, tick_state;
    cnt_t   count, count_n, active_period, active_period_n, start_clip, sync_clip, tick_next;
    logic   running, clear, tick, saw, descend, hit, strobe_n;
    assign running = state != STOPPED;
    assign clear = !running || !bus.enable || bus.sync_in;
    assign bus.counter_value = count;
    pwm_prescaler #(.WIDTH(PRESCALER_WIDTH)) prescaler (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear),
        .divisor(bus.prescale),
        .tick   (tick)
    );
    // A zero period degenerates to a held-zero count in both carrier shapes
    always_comb begin
        start_clip = bus.start_value > bus.period ? bus.period : bus.start_value;
        sync_clip = bus.start_value > active_period ? active_period : bus.start_value;
        saw = bus.mode == SAWTOOTH || active_period == '0;
        descend = !saw && (state == COUNT_DOWN || count >= active_period);
        tick_next = saw ? (count >= active_period ? '0 : count + 1'b1) :
                    descend ? (count >= active_period ? active_period - 1'b1 : count - 1'b1) :
                    count + 1'b1;
        tick_state = (descend && tick_next != '0) ? COUNT_DOWN : COUNT_UP;
        hit = reload_hit(bus.reload_sel, tick_next == '0, tick_next == active_period);
    end
    always_comb begin
        state_n = state;
        count_n = count;
        active_period_n = active_period;
        strobe_n = 1'b0;
        if (!running) begin
            active_period_n = bus.period;
            count_n = start_clip;
            state_n = bus.enable ? COUNT_UP : STOPPED;
        end else if (!bus.enable) begin
            state_n = STOPPED;
            count_n = start_clip;
        end else if (bus.sync_in) begin
            state_n = COUNT_UP;
            count_n = sync_clip;
        end else if (tick) begin
            state_n = tick_state;
            count_n = tick_next;
            strobe_n = hit;
            active_period_n = hit ? bus.period : active_period;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= STOPPED;
            count <= '0;
            active_period <= '0;
            bus.reload_compare <= 1'b0;
            bus.direction <= 1'b0;
            bus.counter_stopped <= 1'b1;
        end else begin
            state <= state_n;
            count <= count_n;
            active_period <= active_period_n;
            bus.reload_compare <= strobe_n;
            bus.direction <= state_n == COUNT_DOWN;
            bus.counter_stopped <= state_n == STOPPED;
        end
    end
endmodule
